light_sequencer: RTL and testbench
==================================

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 Parameter CNT_W, default 4, SHALL set the width of time_value and of the interval counter.
REQ-002 clk  in  1  system clock; all state changes on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 tick  in  1  one-cycle enable pulse, nominally 1 Hz; the only event that decrements the interval counter.
REQ-005 sensor  in  1  side-road vehicle present, synchronous level.
REQ-006 walk_req  in  1  pedestrian button, synchronous, pulse or level.
REQ-007 time_value  in  CNT_W  interval length from the time-parameter store; valid one cycle after interval_code changes.
REQ-008 interval_code  out  2  interval select to the time-parameter store: 00 base, 01 ext, 10 yellow; 11 never driven.
REQ-009 main_light  out  3  {red,yellow,green} one-hot for the main road.
REQ-010 side_light  out  3  {red,yellow,green} one-hot for the side road.
REQ-011 walk_light  out  1  pedestrian walk lamp.
REQ-012 state_dbg  out  3  current state encoding, for observation only.

Function
REQ-013 States and codes SHALL be: MAIN_BASE(00), MAIN_EXT(01), MAIN_YEL(10), WALK(01), SIDE_BASE(00), SIDE_EXT(01), SIDE_YEL(10); interval_code is registered and changes on the same edge as the state.
REQ-014 Lights per state SHALL be: MAIN_BASE/MAIN_EXT main=001, side=100; MAIN_YEL main=010, side=100; WALK main=100, side=100, walk_light=1; SIDE_BASE/SIDE_EXT main=100, side=001; SIDE_YEL main=100, side=010; walk_light=0 outside WALK.
REQ-015 On every state entry, a 2-bit load_pend SHALL be set to 2 and decremented each clk; the counter loads time_value on the edge where load_pend goes 1->0; no tick is honoured while load_pend != 0.
REQ-016 When load_pend = 0, each tick SHALL decrement the counter; expiry is a tick with counter <= 1; a loaded value of 0 SHALL expire on the first honoured tick.
REQ-017 Transitions on expiry SHALL be: MAIN_BASE -> MAIN_EXT if sensor=1, else MAIN_YEL; MAIN_EXT -> MAIN_YEL; MAIN_YEL -> WALK if walk_pend=1, else SIDE_BASE; WALK -> SIDE_BASE; SIDE_BASE -> SIDE_EXT if sensor=1, else SIDE_YEL; SIDE_EXT -> SIDE_YEL; SIDE_YEL -> MAIN_BASE.
REQ-018 walk_pend SHALL set on any cycle with walk_req=1 and clear on the edge entering WALK; walk_req high on that same edge is consumed, not re-latched.
REQ-019 sensor SHALL be sampled only on the expiry edge; its value at other times is ignored.
REQ-020 Every state SHALL last at least 2 clk + 1 tick; there are no transitions without expiry.
REQ-021 Outputs SHALL never show green or yellow on both roads at once; any other combination is an assertion failure.
REQ-022 Counter arithmetic SHALL be unsigned CNT_W bits with no wrap; the counter does not decrement below 0.

Reset
REQ-023 reset=1 SHALL immediately force: state MAIN_BASE, interval_code=00, main_light=001, side_light=100, walk_light=0, counter=0, load_pend=2, walk_pend=0.
REQ-024 Reset asserted mid-interval SHALL abandon the interval; after release, the full MAIN_BASE load sequence of REQ-015 restarts.
REQ-025 Ticks during reset and during the 2 post-reset load cycles SHALL be ignored.

Verification
REQ-026 time_value follows code (base 6, ext 3, yel 2), sensor=0, no walk, tick every 4 clk -> MAIN_BASE 6 ticks, MAIN_YEL 2, SIDE_BASE 6, SIDE_YEL 2, back to MAIN_BASE; interval_code sequence 00,10,00,10.
REQ-027 sensor=1 held -> MAIN_BASE 6, MAIN_EXT 3 (code 01), MAIN_YEL 2, SIDE_BASE 6, SIDE_EXT 3, SIDE_YEL 2.
REQ-028 walk_req pulse during MAIN_BASE -> after MAIN_YEL, WALK for 3 ticks with all reds and walk_light=1, then SIDE_BASE; a second cycle without a request skips WALK.
REQ-029 tick asserted every clk -> first honoured tick only after load_pend=0; MAIN_BASE lasts exactly 2+6 clk; time_value=0 -> state expires on first honoured tick.
REQ-030 reset pulsed during SIDE_EXT -> outputs show main=001, side=100, code 00 within the reset cycle; next MAIN_BASE lasts full 6 ticks.

Source files
------------

// File: rtl/light_sequencer_if.sv
// light_sequencer_if
//   Connection between the light sequencer and the time-parameter store.
//   The sequencer selects an interval with interval_code; the store answers
//   with the interval length on time_value one clock later.
//
//   Signals:
//     interval_code  2      interval select: 00 base, 01 ext, 10 yellow
//     time_value     CNT_W  interval length in ticks for the selected code
//
//   Modports:
//     master  the sequencer (drives interval_code, reads time_value)
//     slave   the time-parameter store
interface light_sequencer_if #(
    parameter int CNT_W = 4
) ();

    logic [1:0]       interval_code;
    logic [CNT_W-1:0] time_value;

    modport master (
        output interval_code,
        input  time_value
    );

    modport slave (
        input  interval_code,
        output time_value
    );

endinterface

// File: rtl/light_sequencer.sv
// light_sequencer
//   Traffic light controller for a main road / side road crossing with a
//   pedestrian walk phase. Each state requests an interval length from the
//   time-parameter store, waits two clocks for the value to settle, loads it,
//   and then counts down on tick pulses. On expiry the next state is chosen
//   from the sensor and the latched walk request.
//
//   Ports:
//     clk         system clock, rising edge
//     reset       asynchronous, active-high
//     tick        one-cycle enable; the only event that counts an interval down
//     sensor      side-road vehicle present, sampled on the expiry edge only
//     walk_req    pedestrian button (pulse or level), latched into walk_pend
//     tp          time-parameter store connection (interval_code / time_value)
//     main_light  {red,yellow,green} one-hot, main road
//     side_light  {red,yellow,green} one-hot, side road
//     walk_light  pedestrian walk lamp
//     state_dbg   current state encoding, observation only
module light_sequencer #(
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     tick,
    input  logic                     sensor,
    input  logic                     walk_req,
    light_sequencer_if.master        tp,
    output logic [2:0]               main_light,
    output logic [2:0]               side_light,
    output logic                     walk_light,
    output logic [2:0]               state_dbg
);

    typedef enum logic [2:0] {
        MAIN_BASE = 3'd0,
        MAIN_EXT  = 3'd1,
        MAIN_YEL  = 3'd2,
        WALK      = 3'd3,
        SIDE_BASE = 3'd4,
        SIDE_EXT  = 3'd5,
        SIDE_YEL  = 3'd6
    } state_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam logic [1:0] CODE_BASE = 2'b00;
    localparam logic [1:0] CODE_EXT  = 2'b01;
    localparam logic [1:0] CODE_YEL  = 2'b10;

    localparam logic [1:0] LOAD_WAIT = 2'd2;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       code_q;
    logic [1:0]       load_pend_q;
    logic [CNT_W-1:0] cnt_q;
    logic             walk_pend_q;

    logic             honoured;
    logic             expire;

    // Interval select requested from the store while in a given state.
    function automatic logic [1:0] code_of(input state_t s);
        logic [1:0] c;
        c = CODE_BASE;
        case (s)
            MAIN_EXT, WALK, SIDE_EXT: c = CODE_EXT;
            MAIN_YEL, SIDE_YEL:       c = CODE_YEL;
            default:                  c = CODE_BASE;
        endcase
        return c;
    endfunction

    // A tick only counts once the interval has been loaded. Expiry fires on
    // the tick that finds the counter at 1 or 0, so a loaded 0 expires on
    // the first honoured tick and the counter never has to go below 0.
    always_comb begin
        honoured = tick && (load_pend_q == 2'd0);
        expire   = honoured && (cnt_q <= CNT_W'(1));
    end

    // Next-state logic: only an expiry moves the FSM.
    always_comb begin
        state_d = state_q;
        if (expire) begin
            case (state_q)
                MAIN_BASE: state_d = sensor ? MAIN_EXT : MAIN_YEL;
                MAIN_EXT:  state_d = MAIN_YEL;
                MAIN_YEL:  state_d = walk_pend_q ? WALK : SIDE_BASE;
                WALK:      state_d = SIDE_BASE;
                SIDE_BASE: state_d = sensor ? SIDE_EXT : SIDE_YEL;
                SIDE_EXT:  state_d = SIDE_YEL;
                SIDE_YEL:  state_d = MAIN_BASE;
                default:   state_d = MAIN_BASE;
            endcase
        end
    end

    // Lamp decode from the current state.
    always_comb begin
        main_light = LAMP_RED;
        side_light = LAMP_RED;
        walk_light = 1'b0;
        case (state_q)
            MAIN_BASE, MAIN_EXT: begin
                main_light = LAMP_GRN;
                side_light = LAMP_RED;
            end
            MAIN_YEL: begin
                main_light = LAMP_YEL;
                side_light = LAMP_RED;
            end
            WALK: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
                walk_light = 1'b1;
            end
            SIDE_BASE, SIDE_EXT: begin
                main_light = LAMP_RED;
                side_light = LAMP_GRN;
            end
            SIDE_YEL: begin
                main_light = LAMP_RED;
                side_light = LAMP_YEL;
            end
            default: begin
                main_light = LAMP_RED;
                side_light = LAMP_RED;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MAIN_BASE;
        end else begin
            state_q <= state_d;
        end
    end

    // Interval bookkeeping. interval_code is registered from the next state so
    // it changes on the same edge as the state; time_value follows one clock
    // later and is captured when load_pend steps from 1 to 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_q      <= CODE_BASE;
            load_pend_q <= LOAD_WAIT;
            cnt_q       <= '0;
            walk_pend_q <= 1'b0;
        end else begin
            if (expire) begin
                code_q      <= code_of(state_d);
                load_pend_q <= LOAD_WAIT;
            end else if (load_pend_q != 2'd0) begin
                load_pend_q <= load_pend_q - 2'd1;
            end

            if (load_pend_q == 2'd1) begin
                cnt_q <= tp.time_value;
            end else if (honoured && !expire) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end

            // A request arriving on the edge that enters WALK is served by
            // that WALK phase rather than latched for the next round.
            if (expire && (state_d == WALK)) begin
                walk_pend_q <= 1'b0;
            end else begin
                walk_pend_q <= walk_pend_q | walk_req;
            end
        end
    end

    assign tp.interval_code = code_q;
    assign state_dbg        = state_q;

    // Safety: never green/yellow on both roads, lamps always one-hot,
    // and the unused interval code is never requested.
    a_no_conflict: assert property (@(posedge clk) disable iff (reset)
        !((main_light[1] || main_light[0]) && (side_light[1] || side_light[0])));

    a_lamps_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot(main_light) && $onehot(side_light));

    a_code_legal: assert property (@(posedge clk) disable iff (reset)
        tp.interval_code != 2'b11);

endmodule

// File: tb/tb_light_sequencer.sv
// tb_light_sequencer
//   Self-checking bench for light_sequencer. A phase-level model tracks which
//   phase the crossing is in, how many clocks have passed since entry, and how
//   many honoured ticks have been seen against the interval length; lamps and
//   interval code are looked up from per-phase tables and compared on every
//   falling edge. Directed runs additionally pin phase durations and the
//   interval_code sequence to hand-computed values.
module tb_light_sequencer;

    localparam int CNT_W = 4;

    // Model phase labels (bench-local numbering).
    localparam int P_MB = 0;  // main green, base
    localparam int P_ME = 1;  // main green, extended
    localparam int P_MY = 2;  // main yellow
    localparam int P_SB = 3;  // side green, base
    localparam int P_SE = 4;  // side green, extended
    localparam int P_SY = 5;  // side yellow
    localparam int P_WK = 6;  // pedestrian walk

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       sensor;
    logic       walk_req;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk_light;
    logic [2:0] state_dbg;

    light_sequencer_if #(.CNT_W(CNT_W)) tp ();

    light_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .sensor     (sensor),
        .walk_req   (walk_req),
        .tp         (tp),
        .main_light (main_light),
        .side_light (side_light),
        .walk_light (walk_light),
        .state_dbg  (state_dbg)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    int exp_main [7] = '{1, 1, 2, 4, 4, 4, 4};
    int exp_side [7] = '{4, 4, 4, 1, 1, 2, 4};
    int exp_walk [7] = '{0, 0, 0, 0, 0, 0, 1};
    int exp_code [7] = '{0, 1, 2, 0, 1, 2, 1};

    int tv_tbl [3];
    int tick_mode;
    int tick_cnt;
    bit rnd_in;

    int m_ph;
    int m_age;
    int m_seen;
    int m_len;
    bit m_wp;

    int seg_len [12];
    int seg_code [12];
    int seg_n;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int next_ph(input int p, input bit s, input bit w);
        case (p)
            P_MB:    return s ? P_ME : P_MY;
            P_ME:    return P_MY;
            P_MY:    return w ? P_WK : P_SB;
            P_WK:    return P_SB;
            P_SB:    return s ? P_SE : P_SY;
            P_SE:    return P_SY;
            default: return P_MB;
        endcase
    endfunction

    task automatic model_reset();
        m_ph   = P_MB;
        m_age  = 0;
        m_seen = 0;
        m_len  = 0;
        m_wp   = 1'b0;
    endtask

    // Called just after each rising edge; inputs are still the values that
    // were present at that edge.
    task automatic model_step();
        bit into_walk;
        into_walk = 1'b0;
        if (reset) begin
            model_reset();
        end else begin
            if (m_age < 2) begin
                m_age++;
                if (m_age == 2) begin
                    m_len  = int'(tp.time_value);
                    m_seen = 0;
                end
            end else if (tick) begin
                m_seen++;
                if (m_seen >= m_len) begin
                    m_ph      = next_ph(m_ph, sensor, m_wp);
                    into_walk = (m_ph == P_WK);
                    m_age     = 0;
                end
            end
            m_wp = into_walk ? 1'b0 : (m_wp | walk_req);
        end
    endtask

    task automatic check_model();
        chk("main_light", int'(main_light), exp_main[m_ph]);
        chk("side_light", int'(side_light), exp_side[m_ph]);
        chk("walk_light", int'(walk_light), exp_walk[m_ph]);
        chk("interval_code", int'(tp.interval_code), exp_code[m_ph]);
    endtask

    // Runs at the falling edge: new tick/sensor/walk and the store's answer.
    task automatic drive_inputs();
        case (tick_mode)
            0: tick = 1'b1;
            1: begin
                tick = (tick_cnt % 4 == 0);
                tick_cnt++;
            end
            default: tick = ($urandom_range(0, 2) == 0);
        endcase
        if (rnd_in) begin
            sensor   = $urandom_range(0, 1) == 1;
            walk_req = $urandom_range(0, 7) == 0;
        end else begin
            walk_req = 1'b0;
        end
        tp.time_value = (tp.interval_code == 2'b11) ? '0
                                                    : CNT_W'(tv_tbl[tp.interval_code]);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_model();
        drive_inputs();
    endtask

    // Assert reset at a falling edge, hold for n clocks, release at a falling edge.
    task automatic do_reset(input int n);
        reset = 1'b1;
        model_reset();
        #1;
        check_model();
        repeat (n) cycle();
        reset = 1'b0;
    endtask

    // Record lengths (in clocks) and interval codes of the next n phases, a
    // phase being a run of identical {code, lamps}.
    task automatic run_segs(input int n, input int budget);
        logic [8:0] cur;
        logic [8:0] sig;
        int len;
        int cyc;
        cur   = {tp.interval_code, main_light, side_light, walk_light};
        len   = 1;
        seg_n = 0;
        cyc   = 0;
        for (int i = 0; i < 12; i++) begin
            seg_len[i]  = -1;
            seg_code[i] = -1;
        end
        while (seg_n < n && cyc < budget) begin
            cycle();
            cyc++;
            sig = {tp.interval_code, main_light, side_light, walk_light};
            if (sig == cur) begin
                len++;
            end else begin
                seg_len[seg_n]  = len;
                seg_code[seg_n] = int'(cur[8:7]);
                seg_n++;
                cur = sig;
                len = 1;
            end
        end
        chk("segment_budget", seg_n, n);
    endtask

    initial begin : main
        int e_plain_len  [4] = '{8, 4, 8, 4};
        int e_plain_code [4] = '{0, 2, 0, 2};
        int e_sens_len   [6] = '{8, 5, 4, 8, 5, 4};
        int e_sens_code  [6] = '{0, 1, 2, 0, 1, 2};
        int e_walk_len   [8] = '{8, 4, 5, 8, 4, 8, 4, 8};
        int e_walk_code  [8] = '{0, 2, 1, 0, 2, 0, 2, 0};
        bit found;

        reset         = 1'b0;
        tick          = 1'b1;
        sensor        = 1'b0;
        walk_req      = 1'b0;
        tp.time_value = '0;
        tick_mode     = 0;
        tick_cnt      = 0;
        rnd_in        = 1'b0;
        tv_tbl        = '{6, 3, 2};
        model_reset();

        #1 reset = 1'b1;
        @(negedge clk);
        chk("reset_main", int'(main_light), 1);
        chk("reset_side", int'(side_light), 4);
        chk("reset_walk", int'(walk_light), 0);
        chk("reset_code", int'(tp.interval_code), 0);
        check_model();
        drive_inputs();
        repeat (2) cycle();
        reset = 1'b0;

        // Tick every clock, no sensor, no walk: 2 load clocks + N ticks per phase.
        run_segs(4, 200);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("plain_len%0d", i), seg_len[i], e_plain_len[i]);
            chk($sformatf("plain_code%0d", i), seg_code[i], e_plain_code[i]);
        end

        // Sensor held high: extended phases on both roads.
        sensor = 1'b1;
        do_reset(2);
        run_segs(6, 300);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("sens_len%0d", i), seg_len[i], e_sens_len[i]);
            chk($sformatf("sens_code%0d", i), seg_code[i], e_sens_code[i]);
        end

        // Single walk pulse during main green; the second round skips WALK.
        sensor = 1'b0;
        do_reset(2);
        walk_req = 1'b1;
        run_segs(8, 400);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("walk_len%0d", i), seg_len[i], e_walk_len[i]);
            chk($sformatf("walk_code%0d", i), seg_code[i], e_walk_code[i]);
        end

        // Tick every 4 clocks: interval_code walks 00,10,00,10.
        tick_mode = 1;
        tick_cnt  = 0;
        do_reset(3);
        run_segs(4, 400);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("slow_code%0d", i), seg_code[i], e_plain_code[i]);
        end

        // Zero-length interval expires on the first honoured tick.
        tick_mode = 0;
        tv_tbl    = '{0, 3, 2};
        do_reset(2);
        run_segs(1, 50);
        chk("zero_len", seg_len[0], 3);

        // Reset in the middle of SIDE_EXT, then a full-length MAIN_BASE.
        tv_tbl = '{6, 3, 2};
        sensor = 1'b1;
        do_reset(2);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cycle();
            found = (side_light == 3'b001) && (tp.interval_code == 2'b01);
        end
        chk("reach_side_ext", int'(found), 1);
        cycle();
        reset = 1'b1;
        model_reset();
        #1;
        chk("midrst_main", int'(main_light), 1);
        chk("midrst_side", int'(side_light), 4);
        chk("midrst_code", int'(tp.interval_code), 0);
        check_model();
        repeat (2) cycle();
        reset = 1'b0;
        run_segs(1, 50);
        chk("midrst_mb_len", seg_len[0], 8);

        // Randomized traffic with occasional resets.
        rnd_in = 1'b1;
        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 3; k++) tv_tbl[k] = $urandom_range(0, 6);
            tick_mode = $urandom_range(0, 2);
            tick_cnt  = 0;
            if ($urandom_range(0, 4) == 0) do_reset($urandom_range(1, 3));
            repeat (150) cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
